// File: rtl/mult8_prod_accum.sv
// Product accumulator: sums up to LEN multiplier products per vector
// and presents the dot-product result under a valid/ready handshake.
module mult8_prod_accum #(
    parameter int PROD_W = 16,
    parameter int LEN    = 8,
    parameter int ACC_W  = 19,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ACC_W-1:0] sum_n;
    logic [CNT_W-1:0] count_n;
    logic             ready_n;
    logic             valid_n;

    logic             accept;
    logic             final_el;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = in_valid & in_ready;
    assign final_el = in_last | (cnt == CNT_W'(LEN - 1));
    assign acc_add  = acc + ACC_W'(in_prod);
    assign cnt_inc  = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_sum   <= sum_n;
            out_count <= count_n;
            in_ready  <= ready_n;
            out_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        sum_n   = out_sum;
        count_n = out_count;
        ready_n = in_ready;
        valid_n = out_valid;
        if (clear) begin
            // abort wins over any handshake seen this cycle
            state_n = S_ACC;
            acc_n   = '0;
            cnt_n   = '0;
            valid_n = 1'b0;
            ready_n = 1'b1;
        end else begin
            unique case (state)
                S_ACC: begin
                    ready_n = 1'b1;
                    valid_n = 1'b0;
                    if (accept) begin
                        if (final_el) begin
                            sum_n   = acc_add;
                            count_n = cnt_inc;
                            acc_n   = '0;
                            cnt_n   = '0;
                            valid_n = 1'b1;
                            ready_n = 1'b0;
                            state_n = S_HOLD;
                        end else begin
                            acc_n = acc_add;
                            cnt_n = cnt_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        valid_n = 1'b0;
                        ready_n = 1'b1;
                        state_n = S_ACC;
                    end
                end
                default: begin
                    state_n = S_ACC;
                end
            endcase
        end
    end

endmodule
